// File: rtl/pool_layer_sequencer.sv
// Pooling-layer sequencer: walks each channel of an MxM feature map,
// streams pixels into a pooling unit and stores its results.
module pool_layer_sequencer #(
    parameter int M    = 26,
    parameter int P    = 2,
    parameter int N_CH = 4,
    parameter int AW   = 16,
    localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic          clk,
    input  logic          master_rst,
    input  logic          start,
    input  logic          stall,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          ce,
    output logic          pool_rst,
    input  logic          pool_op_en,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [CW-1:0] channel,
    output logic          busy,
    output logic          done
);

    localparam int Q  = (M / P) * (M / P);
    localparam int OW = $clog2(Q + 1);
    localparam int RW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        NEXT,
        FIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [RW-1:0]   row;
    logic [RW-1:0]   col;
    logic [OW-1:0]   out_cnt;
    logic            last_px;
    logic            out_full;

    assign last_px  = (row == RW'(M - 1)) && (col == RW'(M - 1));
    assign out_full = (out_cnt == OW'(Q));

    assign rd_addr = AW'(channel) * AW'(M * M)
                   + AW'(row) * AW'(M)
                   + AW'(col);
    assign wr_addr = AW'(channel) * AW'(Q) + AW'(out_cnt);

    // Results are accepted in any state until the channel quota is met.
    assign wr_en = pool_op_en && !out_full && !master_rst;

    // State register.
    always_ff @(posedge clk) begin
        if (master_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pixel walk, result counter, channel index and read-latency delay.
    always_ff @(posedge clk) begin
        if (master_rst) begin
            row     <= '0;
            col     <= '0;
            out_cnt <= '0;
            channel <= '0;
            ce      <= 1'b0;
        end else begin
            ce <= rd_en;
            if (rd_en) begin
                if (col == RW'(M - 1)) begin
                    col <= '0;
                    row <= last_px ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (wr_en) begin
                out_cnt <= out_cnt + 1'b1;
            end
            if (state == NEXT) begin
                row     <= '0;
                col     <= '0;
                out_cnt <= '0;
                if (channel != CW'(N_CH - 1)) begin
                    channel <= channel + 1'b1;
                end
            end
            if (state == FIN) begin
                channel <= '0;
            end
        end
    end

    // Next-state and control outputs; reset overrides everything.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        pool_rst  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                busy      = 1'b1;
                pool_rst  = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                busy  = 1'b1;
                rd_en = !stall;
                if (!stall && last_px) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (out_full) state_nxt = NEXT;
            end
            NEXT: begin
                busy = 1'b1;
                if (channel == CW'(N_CH - 1)) begin
                    state_nxt = FIN;
                end else begin
                    state_nxt = CLEAR;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (master_rst) begin
            state_nxt = IDLE;
            rd_en     = 1'b0;
            pool_rst  = 1'b1;
            busy      = 1'b0;
            done      = 1'b0;
        end
    end

endmodule

// File: doc/pool_layer_sequencer.md
POOL_LAYER_SEQUENCER -- requirements
Module: pool_layer_sequencer

Interface
REQ-001 The block SHALL have parameter M, default 26, meaning feature-map width and height in pixels.
REQ-002 The block SHALL have parameter P, default 2, meaning pooling window size; M divisible by P.
REQ-003 The block SHALL have parameter N_CH, default 4, meaning number of channels per layer.
REQ-004 The block SHALL have parameter AW, default 16, meaning read and write address width.
REQ-005 The block SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 The block SHALL have port master_rst  input  1  synchronous active-high reset.
REQ-007 The block SHALL have port start  input  1  single-cycle layer start request, honoured only in IDLE.
REQ-008 The block SHALL have port stall  input  1  downstream backpressure, no new pixel read while high.
REQ-009 The block SHALL have port rd_en  output  1  input-RAM read strobe; data returns one cycle later.
REQ-010 The block SHALL have port rd_addr  output  AW  input-RAM pixel address.
REQ-011 The block SHALL have port ce  output  1  pooling-unit clock enable, marking a valid pixel on the pixel bus.
REQ-012 The block SHALL have port pool_rst  output  1  pooling-unit reset pulse between channels.
REQ-013 The block SHALL have port pool_op_en  input  1  pooling-unit result-valid strobe.
REQ-014 The block SHALL have port wr_en  output  1  output-RAM write strobe.
REQ-015 The block SHALL have port wr_addr  output  AW  output-RAM result address.
REQ-016 The block SHALL have port channel  output  $clog2(N_CH) (minimum 1)  channel currently being processed.
REQ-017 The block SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-018 The block SHALL have port done  output  1  single-cycle layer-complete pulse.

Function
REQ-019 The block SHALL implement the states IDLE, CLEAR, STREAM, DRAIN, NEXT and FIN.
REQ-020 IDLE SHALL go to CLEAR on start; a start received in any other state SHALL be ignored.
REQ-021 CLEAR SHALL last exactly 1 cycle with pool_rst=1, then go to STREAM.
REQ-022 In STREAM, each cycle with stall=0 SHALL issue rd_en=1 with rd_addr = channel*M*M + row*M + col, in row-major order.
REQ-023 Each cycle with stall=1 SHALL hold rd_en=0 and SHALL leave row, col and rd_addr unchanged.
REQ-024 The ce output SHALL equal rd_en delayed by one register, giving a fixed 1-cycle read latency.
REQ-025 After the read at row=M-1, col=M-1, the FSM SHALL go to DRAIN; ce for that last pixel still fires in the following cycle.
REQ-026 In any state, each cycle with pool_op_en=1 SHALL produce wr_en=1 in the same cycle, with wr_addr = channel*(M/P)^2 + out_cnt.
REQ-027 out_cnt SHALL then increment, and SHALL saturate at (M/P)^2; further pool_op_en pulses in the same channel SHALL be dropped with wr_en=0.
REQ-028 DRAIN SHALL go to NEXT in the cycle after out_cnt reaches (M/P)^2.
REQ-029 NEXT SHALL clear row, col and out_cnt; if channel=N_CH-1 it SHALL go to FIN, otherwise it SHALL increment channel and go to CLEAR.
REQ-030 FIN SHALL assert done=1 for 1 cycle, clear channel to 0 and return to IDLE.
REQ-031 busy SHALL be 1 in CLEAR, STREAM, DRAIN and NEXT, and 0 in IDLE and FIN.
REQ-032 Address arithmetic SHALL be unsigned and computed at AW bits; overflow wraps and is the integrator's responsibility.
REQ-033 The block SHALL require M*M*N_CH <= 2^AW.
REQ-034 A stall arriving together with the final read SHALL delay that read; the STREAM-to-DRAIN transition SHALL occur only after the read is actually issued.

Reset
REQ-035 While master_rst=1, the block SHALL enter IDLE with rd_en=0, ce=0, pool_rst=1, wr_en=0, busy=0, done=0, channel=0, rd_addr=0, wr_addr=0, and row, col and out_cnt all 0.
REQ-036 master_rst asserted mid-layer SHALL abort the layer without a done pulse, and the first cycle after release SHALL be IDLE with pool_rst=0.
REQ-037 master_rst SHALL take priority over start, stall and pool_op_en.

Verification
REQ-038 With M=4, P=2, N_CH=1 and no stall: start -> pool_rst at cycle 1, rd_addr 0..15 on cycles 2..17, ce on cycles 3..18; four pool_op_en pulses -> wr_addr 0..3; done exactly once.
REQ-039 With M=4, N_CH=2: channel 1 reads rd_addr 16..31 and writes wr_addr 4..7, preceded by a 1-cycle pool_rst.
REQ-040 Stall held for 3 cycles at rd_addr=5 -> rd_addr stays 5, rd_en=0 for those 3 cycles, no pixel skipped or duplicated, ce gap exactly 3 cycles.
REQ-041 Stall asserted in the cycle of the last read (rd_addr=15) -> DRAIN entered only after address 15 is issued.
REQ-042 A fifth pool_op_en in the same channel -> wr_en stays 0; a start pulse while busy -> no effect.
REQ-043 master_rst in the middle of STREAM -> IDLE with outputs at reset values; a fresh start -> normal run from rd_addr 0.
